compress_line_ctrl: RTL and testbench

//  Sequencer for the two-stage compressor pipeline (matching + length generation).

---
 rtl/compress_line_ctrl.sv | 167 ++++++++++++++++
 tb/tb_compress_line_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_line_ctrl.sv
// compress_line_ctrl
//   Sequencer for a two-stage compressor pipeline (matching + length generation).
//   It takes one CACHE_LINE-bit line per valid/ready handshake and issues it to
//   the matching stage as WIDTH-bit words, low word first. Per-beat lengths and
//   stop flags come back PIPE_LAT cycles after each word. They are accumulated,
//   and the block returns one verdict per line: compressed with its length, or raw.
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_line_valid/o_line_ready/i_line_data   line intake handshake and payload
//   i_abort                drop the current line (ISSUE/DRAIN only), no verdict
//   o_word, o_word_valid   beat to the matching stage (o_word is 0 when not valid)
//   i_total_length, i_stop_flag   stage-2 result for the returning beat
//   o_done_valid/i_done_ready     verdict handshake
//   o_compressed, o_comp_length   verdict: compressed flag and bits to store
//   o_busy                 controller is not idle
//   o_line_count, o_raw_count     delivered verdicts / delivered raw verdicts (wrap)
module compress_line_ctrl #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned CACHE_LINE = 128,
   parameter int unsigned PIPE_LAT   = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_line_valid,
   output logic                  o_line_ready,
   input  logic [CACHE_LINE-1:0] i_line_data,
   input  logic                  i_abort,
   output logic [WIDTH-1:0]      o_word,
   output logic                  o_word_valid,
   input  logic [6:0]            i_total_length,
   input  logic                  i_stop_flag,
   output logic                  o_done_valid,
   input  logic                  i_done_ready,
   output logic                  o_compressed,
   output logic [7:0]            o_comp_length,
   output logic                  o_busy,
   output logic [CNT_W-1:0]      o_line_count,
   output logic [CNT_W-1:0]      o_raw_count
);

   localparam int unsigned BEATS  = CACHE_LINE / WIDTH;
   localparam int unsigned BEAT_W = $clog2(BEATS + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS);
   localparam logic [7:0] RAW_LEN = 8'(CACHE_LINE);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

   state_t                state;
   logic [CACHE_LINE-1:0] line;       // remaining words, next word in the low bits
   logic [BEAT_W-1:0]     beat;       // words issued so far
   logic [BEAT_W-1:0]     rx;         // stage-2 results received so far
   logic [7:0]            acc;
   logic                  stop_sticky;
   logic [PIPE_LAT-1:0]   lat_sr;     // tracks issued beats until their result returns

   logic              tap_live;
   logic [8:0]        acc_sum;
   logic [7:0]        acc_nxt;
   logic              stop_nxt;
   logic [BEAT_W-1:0] rx_nxt;
   logic              comp_nxt;

   // Fold the returning beat in combinationally so that a tap landing on the
   // DRAIN->DONE transition still counts in the verdict.
   always_comb begin
      tap_live = lat_sr[PIPE_LAT-1] && (state == StIssue || state == StDrain);
      acc_sum  = {1'b0, acc} + {2'b00, i_total_length};
      acc_nxt  = acc;
      stop_nxt = stop_sticky;
      rx_nxt   = rx;
      if (tap_live) begin
         acc_nxt  = acc_sum[8] ? 8'hff : acc_sum[7:0];
         stop_nxt = stop_sticky | i_stop_flag;
         rx_nxt   = rx + BEAT_W'(1);
      end
      comp_nxt = !stop_nxt && (32'(acc_nxt) < CACHE_LINE);
   end

   assign o_line_ready = (state == StIdle);
   assign o_busy       = (state != StIdle);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= StIdle;
         line          <= '0;
         beat          <= '0;
         rx            <= '0;
         acc           <= '0;
         stop_sticky   <= 1'b0;
         lat_sr        <= '0;
         o_word        <= '0;
         o_word_valid  <= 1'b0;
         o_done_valid  <= 1'b0;
         o_compressed  <= 1'b0;
         o_comp_length <= '0;
         o_line_count  <= '0;
         o_raw_count   <= '0;
      end else begin
         lat_sr[0] <= o_word_valid;
         for (int i = 1; i < PIPE_LAT; i++) begin
            lat_sr[i] <= lat_sr[i-1];
         end
         if (state == StIssue || state == StDrain) begin
            acc         <= acc_nxt;
            stop_sticky <= stop_nxt;
            rx          <= rx_nxt;
         end

         unique case (state)
            StIdle: begin
               if (i_line_valid) begin
                  o_word       <= i_line_data[WIDTH-1:0];
                  o_word_valid <= 1'b1;
                  line         <= i_line_data >> WIDTH;
                  beat         <= BEAT_W'(1);
                  acc          <= '0;
                  stop_sticky  <= 1'b0;
                  rx           <= '0;
                  state        <= StIssue;
               end
            end
            StIssue: begin
               if (i_abort) begin
                  // Clearing the tracker makes the aborted beats' returns invisible.
                  o_word       <= '0;
                  o_word_valid <= 1'b0;
                  lat_sr       <= '0;
                  state        <= StIdle;
               end else if (beat == LAST_BEAT) begin
                  o_word       <= '0;
                  o_word_valid <= 1'b0;
                  state        <= StDrain;
               end else begin
                  o_word <= line[WIDTH-1:0];
                  line   <= line >> WIDTH;
                  beat   <= beat + BEAT_W'(1);
               end
            end
            StDrain: begin
               if (i_abort) begin
                  lat_sr <= '0;
                  state  <= StIdle;
               end else if (rx_nxt == LAST_BEAT) begin
                  o_done_valid  <= 1'b1;
                  o_compressed  <= comp_nxt;
                  o_comp_length <= comp_nxt ? acc_nxt : RAW_LEN;
                  state         <= StDone;
               end
            end
            StDone: begin
               if (i_done_ready) begin
                  o_done_valid <= 1'b0;
                  o_line_count <= o_line_count + CNT_W'(1);
                  if (!o_compressed) begin
                     o_raw_count <= o_raw_count + CNT_W'(1);
                  end
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_compress_line_ctrl.sv
module tb_compress_line_ctrl;
   localparam int WIDTH      = 64;
   localparam int CACHE_LINE = 128;
   localparam int PIPE_LAT   = 2;
   localparam int CNT_W      = 16;
   localparam int BEATS      = CACHE_LINE / WIDTH;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  i_line_valid;
   logic                  o_line_ready;
   logic [CACHE_LINE-1:0] i_line_data;
   logic                  i_abort;
   logic [WIDTH-1:0]      o_word;
   logic                  o_word_valid;
   logic [6:0]            i_total_length;
   logic                  i_stop_flag;
   logic                  o_done_valid;
   logic                  i_done_ready;
   logic                  o_compressed;
   logic [7:0]            o_comp_length;
   logic                  o_busy;
   logic [CNT_W-1:0]      o_line_count;
   logic [CNT_W-1:0]      o_raw_count;

   always #5 clk = ~clk;

   compress_line_ctrl #(
      .WIDTH(WIDTH), .CACHE_LINE(CACHE_LINE), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_line_valid(i_line_valid), .o_line_ready(o_line_ready), .i_line_data(i_line_data),
      .i_abort(i_abort), .o_word(o_word), .o_word_valid(o_word_valid),
      .i_total_length(i_total_length), .i_stop_flag(i_stop_flag),
      .o_done_valid(o_done_valid), .i_done_ready(i_done_ready),
      .o_compressed(o_compressed), .o_comp_length(o_comp_length), .o_busy(o_busy),
      .o_line_count(o_line_count), .o_raw_count(o_raw_count)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int exp_lines = 0;
   int exp_raw = 0;
   int plan_sum = 0;
   bit plan_stop = 1'b0;

   typedef struct { int due; logic [6:0] len; logic stop; } ret_t;
   ret_t             pend[$];
   logic [6:0]       plan_len_q[$];
   logic             plan_stop_q[$];
   logic [WIDTH-1:0] seen_words[$];
   int               word_zero_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Stage-2 stand-in: every live word gets a result PIPE_LAT cycles later,
   // taken from the test's plan; idle cycles carry random junk.
   initial begin : stage_model
      ret_t r;
      i_total_length = '0;
      i_stop_flag    = 1'b0;
      forever begin
         @(negedge clk);
         if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            i_total_length = r.len;
            i_stop_flag    = r.stop;
         end else begin
            i_total_length = 7'($urandom_range(0, 127));
            i_stop_flag    = 1'($urandom_range(0, 1));
         end
         if (o_word_valid === 1'b1) begin
            r.due = cyc + PIPE_LAT;
            if (plan_len_q.size() > 0) begin
               r.len  = plan_len_q.pop_front();
               r.stop = plan_stop_q.pop_front();
            end else begin
               r.len  = 7'($urandom_range(0, 127));
               r.stop = 1'($urandom_range(0, 1));
            end
            pend.push_back(r);
            seen_words.push_back(o_word);
         end else if (o_word !== '0) begin
            word_zero_bad++;
         end
      end
   end

   function automatic bit ref_comp(int sum, bit stop);
      int acc = (sum > 255) ? 255 : sum;
      return !stop && (acc < CACHE_LINE);
   endfunction

   function automatic int ref_len(int sum, bit stop);
      int acc = (sum > 255) ? 255 : sum;
      return ref_comp(sum, stop) ? acc : (CACHE_LINE % 256);
   endfunction

   task automatic set_plan(input int l0, input int l1, input bit s0, input bit s1);
      plan_len_q.push_back(7'(l0));
      plan_stop_q.push_back(s0);
      plan_len_q.push_back(7'(l1));
      plan_stop_q.push_back(s1);
      plan_sum  = l0 + l1;
      plan_stop = s0 | s1;
   endtask

   task automatic send_line(input logic [CACHE_LINE-1:0] data, output bit ok);
      seen_words.delete();
      ok = 1'b0;
      @(negedge clk);
      i_line_valid = 1'b1;
      i_line_data  = data;
      for (int k = 0; k < 40 && !ok; k++) begin
         if (o_line_ready === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      @(posedge clk);
      #1;
      i_line_valid = 1'b0;
      i_line_data  = {4{$urandom}};
   endtask

   task automatic wait_done(output bit ok, output int waited);
      ok = 1'b0;
      waited = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         waited++;
         if (o_done_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic ack_done();
      i_done_ready = 1'b1;
      @(posedge clk);
      #1;
      i_done_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      n_cmp++; if (o_line_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", o_line_ready); end
      n_cmp++; if (o_word !== '0) begin n_bad++; $display("FAIL reset_word got %h want 0", o_word); end
      n_cmp++; if (o_word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid got %b want 0", o_word_valid); end
      n_cmp++; if (o_done_valid !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_done_valid); end
      n_cmp++; if ({o_compressed, o_comp_length} !== 9'd0) begin n_bad++; $display("FAIL reset_verdict got %b/%0d want 0/0", o_compressed, o_comp_length); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
      n_cmp++; if (o_line_count !== '0 || o_raw_count !== '0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", o_line_count, o_raw_count); end
   endtask

   task automatic test_verdicts();
      logic [CACHE_LINE-1:0] data;
      bit ok_a, ok_d;
      int waited;
      bit ec;
      int el;
      for (int t = 0; t < 3; t++) begin
         case (t)
            0:       begin data = '0;             set_plan(20, 20, 1'b0, 1'b0); end
            1:       begin data = {4{$urandom}}; set_plan(70, 70, 1'b0, 1'b0); end
            default: begin data = {4{$urandom}}; set_plan(10, 10, 1'b0, 1'b1); end
         endcase
         ec = ref_comp(plan_sum, plan_stop);
         el = ref_len(plan_sum, plan_stop);
         send_line(data, ok_a);
         wait_done(ok_d, waited);
         n_cmp++; if (!(ok_a && ok_d)) begin n_bad++; $display("FAIL verdict_timeout case %0d accept=%b done=%b want 1/1", t, ok_a, ok_d); end
         n_cmp++; if (waited !== BEATS + PIPE_LAT + 1) begin n_bad++; $display("FAIL verdict_latency case %0d got %0d want %0d", t, waited, BEATS + PIPE_LAT + 1); end
         n_cmp++; if (o_compressed !== ec) begin n_bad++; $display("FAIL verdict_comp case %0d got %b want %b", t, o_compressed, ec); end
         n_cmp++; if (o_comp_length !== 8'(el)) begin n_bad++; $display("FAIL verdict_len case %0d got %0d want %0d", t, o_comp_length, el); end
         n_cmp++; if (seen_words.size() !== BEATS) begin n_bad++; $display("FAIL verdict_beats case %0d got %0d want %0d", t, seen_words.size(), BEATS); end
         for (int i = 0; i < seen_words.size() && i < BEATS; i++) begin
            n_cmp++; if (seen_words[i] !== data[i*WIDTH +: WIDTH]) begin n_bad++; $display("FAIL verdict_word%0d case %0d got %h want %h", i, t, seen_words[i], data[i*WIDTH +: WIDTH]); end
         end
         ack_done();
         exp_lines++;
         if (!ec) exp_raw++;
         n_cmp++; if (o_line_count !== CNT_W'(exp_lines) || o_raw_count !== CNT_W'(exp_raw)) begin n_bad++; $display("FAIL verdict_counts case %0d got %0d/%0d want %0d/%0d", t, o_line_count, o_raw_count, exp_lines, exp_raw); end
      end
   endtask

   task automatic test_backpressure();
      bit ok_a, ok_d;
      int waited;
      bit ec;
      int el;
      set_plan($urandom_range(0, 60), $urandom_range(0, 60), 1'b0, 1'b0);
      ec = ref_comp(plan_sum, plan_stop);
      el = ref_len(plan_sum, plan_stop);
      send_line({4{$urandom}}, ok_a);
      wait_done(ok_d, waited);
      n_cmp++; if (!(ok_a && ok_d)) begin n_bad++; $display("FAIL bp_timeout accept=%b done=%b want 1/1", ok_a, ok_d); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (o_done_valid !== 1'b1 || o_compressed !== ec || o_comp_length !== 8'(el) || o_line_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold cycle %0d got v=%b c=%b l=%0d r=%b want 1/%b/%0d/0", c, o_done_valid, o_compressed, o_comp_length, o_line_ready, ec, el);
         end
      end
      ack_done();
      exp_lines++;
      if (!ec) exp_raw++;
      n_cmp++; if (o_done_valid !== 1'b0 || o_line_ready !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL bp_release got v=%b r=%b b=%b want 0/1/0", o_done_valid, o_line_ready, o_busy); end
      n_cmp++; if (o_line_count !== CNT_W'(exp_lines) || o_raw_count !== CNT_W'(exp_raw)) begin n_bad++; $display("FAIL bp_counts got %0d/%0d want %0d/%0d", o_line_count, o_raw_count, exp_lines, exp_raw); end
   endtask

   task automatic test_abort();
      bit ok_a, ok_d;
      int waited;
      bit ec;
      int el;
      // Aborted line returns big lengths and a stop; none of it may leak.
      set_plan(100, 100, 1'b1, 1'b1);
      send_line({4{$urandom}}, ok_a);
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (o_word_valid !== 1'b1) begin n_bad++; $display("FAIL abort_beat2 got %b want 1", o_word_valid); end
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort = 1'b0;
      n_cmp++; if (o_word_valid !== 1'b0 || o_busy !== 1'b0 || o_line_ready !== 1'b1 || o_done_valid !== 1'b0) begin n_bad++; $display("FAIL abort_idle got wv=%b b=%b r=%b dv=%b want 0/0/1/0", o_word_valid, o_busy, o_line_ready, o_done_valid); end
      n_cmp++; if (o_line_count !== CNT_W'(exp_lines) || o_raw_count !== CNT_W'(exp_raw)) begin n_bad++; $display("FAIL abort_counts got %0d/%0d want %0d/%0d", o_line_count, o_raw_count, exp_lines, exp_raw); end
      set_plan(30, 40, 1'b0, 1'b0);
      ec = ref_comp(plan_sum, plan_stop);
      el = ref_len(plan_sum, plan_stop);
      send_line({4{$urandom}}, ok_a);
      wait_done(ok_d, waited);
      n_cmp++; if (!(ok_a && ok_d)) begin n_bad++; $display("FAIL abort_next_timeout accept=%b done=%b want 1/1", ok_a, ok_d); end
      n_cmp++; if (o_compressed !== ec || o_comp_length !== 8'(el)) begin n_bad++; $display("FAIL abort_next_verdict got %b/%0d want %b/%0d", o_compressed, o_comp_length, ec, el); end
      ack_done();
      exp_lines++;
      if (!ec) exp_raw++;
      n_cmp++; if (o_line_count !== CNT_W'(exp_lines) || o_raw_count !== CNT_W'(exp_raw)) begin n_bad++; $display("FAIL abort_next_counts got %0d/%0d want %0d/%0d", o_line_count, o_raw_count, exp_lines, exp_raw); end
   endtask

   task automatic test_reset_drain();
      bit ok_a, ok_d, in_drain;
      int waited;
      bit ec;
      int el;
      set_plan(90, 90, 1'b1, 1'b1);
      send_line({4{$urandom}}, ok_a);
      in_drain = 1'b0;
      for (int k = 0; k < 20 && !in_drain; k++) begin
         @(negedge clk);
         if (seen_words.size() == BEATS && o_word_valid === 1'b0) in_drain = 1'b1;
      end
      n_cmp++; if (!in_drain || o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_drain_reach got drain=%b busy=%b want 1/1", in_drain, o_busy); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_lines = 0;
      exp_raw = 0;
      n_cmp++; if (o_busy !== 1'b0 || o_line_ready !== 1'b1 || o_done_valid !== 1'b0 || o_word_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drain_state got b=%b r=%b dv=%b wv=%b want 0/1/0/0", o_busy, o_line_ready, o_done_valid, o_word_valid); end
      n_cmp++; if ({o_compressed, o_comp_length} !== 9'd0 || o_line_count !== '0 || o_raw_count !== '0) begin n_bad++; $display("FAIL rst_drain_regs got %b/%0d/%0d/%0d want 0/0/0/0", o_compressed, o_comp_length, o_line_count, o_raw_count); end
      repeat (3) @(negedge clk);
      n_cmp++; if (o_done_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drain_noverdict got %b want 0", o_done_valid); end
      set_plan(5, 15, 1'b0, 1'b0);
      ec = ref_comp(plan_sum, plan_stop);
      el = ref_len(plan_sum, plan_stop);
      send_line({4{$urandom}}, ok_a);
      wait_done(ok_d, waited);
      n_cmp++; if (!(ok_a && ok_d)) begin n_bad++; $display("FAIL rst_next_timeout accept=%b done=%b want 1/1", ok_a, ok_d); end
      n_cmp++; if (o_compressed !== ec || o_comp_length !== 8'(el)) begin n_bad++; $display("FAIL rst_next_verdict got %b/%0d want %b/%0d", o_compressed, o_comp_length, ec, el); end
      ack_done();
      exp_lines++;
      if (!ec) exp_raw++;
      n_cmp++; if (o_line_count !== CNT_W'(exp_lines) || o_raw_count !== CNT_W'(exp_raw)) begin n_bad++; $display("FAIL rst_next_counts got %0d/%0d want %0d/%0d", o_line_count, o_raw_count, exp_lines, exp_raw); end
   endtask

   task automatic test_back_to_back();
      logic [CACHE_LINE-1:0] data;
      bit ok_a, ok_d;
      int waited;
      bit ec;
      int el;
      for (int n = 0; n < 24; n++) begin
         data = {$urandom, $urandom, $urandom, $urandom};
         set_plan($urandom_range(0, 127), $urandom_range(0, 127),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         ec = ref_comp(plan_sum, plan_stop);
         el = ref_len(plan_sum, plan_stop);
         send_line(data, ok_a);
         wait_done(ok_d, waited);
         n_cmp++; if (!(ok_a && ok_d)) begin n_bad++; $display("FAIL b2b_timeout line %0d accept=%b done=%b want 1/1", n, ok_a, ok_d); end
         n_cmp++; if (o_compressed !== ec || o_comp_length !== 8'(el)) begin n_bad++; $display("FAIL b2b_verdict line %0d got %b/%0d want %b/%0d", n, o_compressed, o_comp_length, ec, el); end
         n_cmp++; if (seen_words.size() !== BEATS) begin n_bad++; $display("FAIL b2b_beats line %0d got %0d want %0d", n, seen_words.size(), BEATS); end
         for (int i = 0; i < seen_words.size() && i < BEATS; i++) begin
            n_cmp++; if (seen_words[i] !== data[i*WIDTH +: WIDTH]) begin n_bad++; $display("FAIL b2b_word%0d line %0d got %h want %h", i, n, seen_words[i], data[i*WIDTH +: WIDTH]); end
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ack_done();
         exp_lines++;
         if (!ec) exp_raw++;
         n_cmp++; if (o_line_count !== CNT_W'(exp_lines) || o_raw_count !== CNT_W'(exp_raw)) begin n_bad++; $display("FAIL b2b_counts line %0d got %0d/%0d want %0d/%0d", n, o_line_count, o_raw_count, exp_lines, exp_raw); end
      end
      n_cmp++; if (word_zero_bad !== 0) begin n_bad++; $display("FAIL idle_word_zero got %0d nonzero idle words want 0", word_zero_bad); end
   endtask

   initial begin
      reset        = 1'b1;
      i_line_valid = 1'b0;
      i_line_data  = '0;
      i_abort      = 1'b0;
      i_done_ready = 1'b0;
      test_reset();
      test_verdicts();
      test_backpressure();
      test_abort();
      test_reset_drain();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
